fwd_hazard_ctrl: RTL and testbench

//  Forwarding/hazard controller for the 5-stage pipeline. Tracks dest regs of the EX, MEM, WB stages
//  in internal shadow registers, drives the 2-bit selects of both EX-operand 3:1 muxes
//  (00=regfile, 01=EX/MEM result, 10=MEM/WB result; 11 never driven), and sequences load-use stalls,

---
 rtl/fwd_hazard_ctrl_if.sv | 49 ++++
 rtl/fwd_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Groups the signals between the pipeline datapath and the forwarding/hazard
// controller.
//   master : pipeline side. It drives the ID instruction fields, ex_flush and
//            mem_busy, and it receives the mux selects and the stall controls.
//   slave  : controller side (fwd_hazard_ctrl).
// Signals
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite,
//   id_memread                  : instruction currently in ID
//   ex_flush                    : taken branch/jump resolved in EX
//   mem_busy                    : data memory not ready this cycle
//   fwd_a_sel, fwd_b_sel        : EX operand mux selects
//                                 (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   pc_hold, ifid_hold,
//   idex_bubble, pipe_freeze    : pipeline stall/flush/freeze controls
// ---------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              ex_flush;
  logic              mem_busy;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              pc_hold;
  logic              ifid_hold;
  logic              idex_bubble;
  logic              pipe_freeze;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, ex_flush, mem_busy,
    input  fwd_a_sel, fwd_b_sel, pc_hold, ifid_hold, idex_bubble, pipe_freeze
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, ex_flush, mem_busy,
    output fwd_a_sel, fwd_b_sel, pc_hold, ifid_hold, idex_bubble, pipe_freeze
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and hazard controller for a 5-stage pipeline. Shadow registers
// track the EX, MEM and WB destination registers. From them the block derives
// the operand-forwarding selects. It also sequences load-use stalls, branch
// flushes and freezes while the data memory is busy.
// Ports
//   clk       : pipeline clock, rising edge
//   rst_n     : asynchronous active-low reset. All outputs are forced to 0
//               while it is low.
//   bus       : fwd_hazard_ctrl_if.slave (ID fields, ex_flush, mem_busy in;
//               selects and stall controls out)
//   lu_cnt    : (HAZARD_STATS_EN only) cycles with a load-use stall
//   wait_cnt  : (HAZARD_STATS_EN only) cycles with the pipeline frozen
// Configuration
//   Define HAZARD_STATS_EN to add the lu_cnt/wait_cnt statistics counters.
// Selects and stall controls are combinational. The selects are valid in the
// same cycle as the EX shadow. Stall and bubble are valid in the same cycle as
// the ID fields.
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_ctrl_if.slave   bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]        lu_cnt,
  output logic [31:0]        wait_cnt
`endif
);

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t state_r;
  state_t state_nx;

  // EX shadow
  logic [REG_AW-1:0] ex_rs_r, ex_rt_r, ex_rd_r;
  logic              ex_use_rs_r, ex_use_rt_r, ex_we_r, ex_ld_r, ex_v_r;
  // MEM shadow
  logic [REG_AW-1:0] mem_rd_r;
  logic              mem_we_r, mem_ld_r, mem_v_r;
  // WB shadow
  logic [REG_AW-1:0] wb_rd_r;
  logic              wb_we_r, wb_v_r;

  logic       lu_s;
  logic       freeze_s;
  logic       flush_kill_s;
  logic       lu_stall_s;
  logic       bubble_s;
  logic [1:0] sel_a_s;
  logic [1:0] sel_b_s;

  // Newest producer wins: a MEM match takes priority over a WB match. r0 is
  // never forwarded. A load in MEM is skipped because the load-use stall
  // keeps a consumer out of EX in that case.
  function automatic logic [1:0] fwd_sel(
    input logic              ex_v,
    input logic              use_src,
    input logic [REG_AW-1:0] src,
    input logic              m_v,
    input logic              m_we,
    input logic              m_ld,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_v,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (ex_v && use_src && (src != REG_ZERO)) begin
      if (m_v && m_we && !m_ld && (m_rd == src)) begin
        sel = SEL_MEM;
      end else if (w_v && w_we && (w_rd == src)) begin
        sel = SEL_WB;
      end else begin
        sel = SEL_RF;
      end
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Operand-forwarding selects from the shadow registers
  always_comb begin
    sel_a_s = fwd_sel(ex_v_r, ex_use_rs_r, ex_rs_r, mem_v_r, mem_we_r, mem_ld_r,
                      mem_rd_r, wb_v_r, wb_we_r, wb_rd_r);
    sel_b_s = fwd_sel(ex_v_r, ex_use_rt_r, ex_rt_r, mem_v_r, mem_we_r, mem_ld_r,
                      mem_rd_r, wb_v_r, wb_we_r, wb_rd_r);
  end

  // Load-use detection: the load in EX writes a register that ID reads
  always_comb begin
    lu_s = 1'b0;
    if (bus.id_valid && ex_v_r && ex_ld_r && ex_we_r && (ex_rd_r != REG_ZERO)) begin
      lu_s = (bus.id_use_rs && (bus.id_rs == ex_rd_r)) ||
             (bus.id_use_rt && (bus.id_rt == ex_rd_r));
    end else begin
      lu_s = 1'b0;
    end
  end

  // Stall/flush FSM: next state and control decisions
  always_comb begin
    state_nx     = state_r;
    freeze_s     = 1'b0;
    flush_kill_s = 1'b0;
    lu_stall_s   = 1'b0;
    if (!rst_n) begin
      state_nx = ST_RUN;
    end else begin
      case (state_r)
        // The cycle that leaves WAIT is evaluated as RUN, so both states share
        // the same decision tree. A busy memory overrides flush and load-use.
        ST_RUN, ST_WAIT: begin
          if (bus.mem_busy) begin
            state_nx = ST_WAIT;
            freeze_s = 1'b1;
          end else begin
            state_nx = ST_RUN;
            if (bus.ex_flush) begin
              flush_kill_s = 1'b1;
            end else if (lu_s) begin
              lu_stall_s = 1'b1;
            end else begin
              lu_stall_s = 1'b0;
            end
          end
        end
        default: begin
          state_nx = ST_RUN;
        end
      endcase
    end
  end

  assign bubble_s = flush_kill_s | lu_stall_s;

  // Output drive. Sels are zero during reset because the shadows are cleared.
  always_comb begin
    bus.fwd_a_sel   = sel_a_s;
    bus.fwd_b_sel   = sel_b_s;
    bus.pipe_freeze = freeze_s;
    bus.pc_hold     = freeze_s | lu_stall_s;
    bus.ifid_hold   = freeze_s | lu_stall_s;
    bus.idex_bubble = bubble_s;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nx;
    end
  end

  // Shadow pipeline: advances unless frozen; a bubble enters EX as invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_r     <= REG_ZERO;
      ex_rt_r     <= REG_ZERO;
      ex_rd_r     <= REG_ZERO;
      ex_use_rs_r <= 1'b0;
      ex_use_rt_r <= 1'b0;
      ex_we_r     <= 1'b0;
      ex_ld_r     <= 1'b0;
      ex_v_r      <= 1'b0;
      mem_rd_r    <= REG_ZERO;
      mem_we_r    <= 1'b0;
      mem_ld_r    <= 1'b0;
      mem_v_r     <= 1'b0;
      wb_rd_r     <= REG_ZERO;
      wb_we_r     <= 1'b0;
      wb_v_r      <= 1'b0;
    end else if (!freeze_s) begin
      wb_rd_r     <= mem_rd_r;
      wb_we_r     <= mem_we_r;
      wb_v_r      <= mem_v_r;
      mem_rd_r    <= ex_rd_r;
      mem_we_r    <= ex_we_r;
      mem_ld_r    <= ex_ld_r;
      mem_v_r     <= ex_v_r;
      ex_rs_r     <= bus.id_rs;
      ex_rt_r     <= bus.id_rt;
      ex_rd_r     <= bus.id_rd;
      ex_use_rs_r <= bus.id_use_rs & ~bubble_s;
      ex_use_rt_r <= bus.id_use_rt & ~bubble_s;
      ex_we_r     <= bus.id_regwrite & ~bubble_s;
      ex_ld_r     <= bus.id_memread & ~bubble_s;
      ex_v_r      <= bus.id_valid & ~bubble_s;
    end
  end

`ifdef HAZARD_STATS_EN
  // Statistics: load-use stall cycles and frozen (wait) cycles, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt   <= 32'd0;
      wait_cnt <= 32'd0;
    end else begin
      if (lu_stall_s) begin
        lu_cnt <= lu_cnt + 32'd1;
      end
      if (freeze_s) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Directed instruction sequences for the forwarding/hazard controller. Each
// step drives the ID fields and pushes a hand-computed expected output vector
// {fwd_a_sel, fwd_b_sel, pc_hold, ifid_hold, idex_bubble, pipe_freeze}. A
// monitor process pops the vector on the falling edge and compares it with the
// DUT outputs.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] lu_cnt;
  logic [31:0] wait_cnt;
  logic [31:0] lu_snap;
  logic [31:0] wait_snap;
`endif

  fwd_hazard_ctrl #(.REG_AW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef HAZARD_STATS_EN
    ,
    .lu_cnt   (lu_cnt),
    .wait_cnt (wait_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  string       name_q[$];
  logic        stim_done = 1'b0;
  logic [7:0]  act_v;
  logic [7:0]  mon_exp;
  string       mon_name;

  assign act_v = {bus.fwd_a_sel, bus.fwd_b_sel, bus.pc_hold, bus.ifid_hold,
                  bus.idex_bubble, bus.pipe_freeze};

  task automatic step(input logic rstv, input logic v,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic fl, input logic busy,
                      input logic [7:0] exp_v, input string nm);
    @(posedge clk);
    #1;
    rst_n           = rstv;
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.id_rd       = rd;
    bus.id_regwrite = we;
    bus.id_memread  = ld;
    bus.ex_flush    = fl;
    bus.mem_busy    = busy;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
  endtask

  task automatic nop(input logic busy, input logic [7:0] exp_v, input string nm);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, busy, exp_v, nm);
  endtask

  // Stimulus
  initial begin
    rst_n           = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_use_rs   = 1'b0;
    bus.id_use_rt   = 1'b0;
    bus.id_rd       = 5'd0;
    bus.id_regwrite = 1'b0;
    bus.id_memread  = 1'b0;
    bus.ex_flush    = 1'b0;
    bus.mem_busy    = 1'b0;

    // reset state, even with mem_busy high
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "rst_busy");
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "rst_idle");
    nop(1'b0, 8'h00, "rst_release");

    // forwarding from MEM then WB; MEM beats WB
    step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "add_r3");
    step(1'b1, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "sub_r4");
    step(1'b1, 1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0100_0000, "fwd_a_mem");
    step(1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'b1000_0000, "fwd_a_wb");
    step(1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "add_r3_again");
    step(1'b1, 1'b1, 5'd9, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "xor_r8");
    nop(1'b0, 8'b0001_0000, "fwd_b_mem_wins");

    // load-use stall then WB forward
    step(1'b1, 1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "lw_r5");
    step(1'b1, 1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_1110, "lu_stall");
    step(1'b1, 1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "lu_one_cycle");
    nop(1'b0, 8'b1000_0000, "lu_fwd_wb");

    // r0 never forwarded, lw r0 never stalls
    step(1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "add_r0_a");
    step(1'b1, 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "add_r0_b");
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "read_r0");
    nop(1'b0, 8'h00, "r0_no_fwd");
    step(1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "lw_r0");
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "lw_r0_no_stall");
    nop(1'b0, 8'h00, "use_r0_ex");

    // flush and load-use in the same cycle
    step(1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "lw_r7");
    step(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 8'b0000_0010, "flush_beats_lu");
    nop(1'b0, 8'h00, "after_flush_a");
    nop(1'b0, 8'h00, "after_flush_b");

    // 3-cycle memory wait with a live MEM forward: shadows must not move
    step(1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "add_r14");
    step(1'b1, 1'b1, 5'd14, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "add_r15");
    nop(1'b1, 8'b0100_1101, "freeze_1");
    nop(1'b1, 8'b0100_1101, "freeze_2");
    nop(1'b1, 8'b0100_1101, "freeze_3");
    nop(1'b0, 8'b0100_0000, "unfreeze");

    // load-use ignored while frozen, applied in the release cycle
    step(1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "lw_r16");
    step(1'b1, 1'b1, 5'd16, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_1101, "lu_frozen");
    step(1'b1, 1'b1, 5'd16, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_1110, "lu_on_release");
    step(1'b1, 1'b1, 5'd16, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "lu_done");
    nop(1'b0, 8'b1000_0000, "fwd_after_wait");

    step(1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd18, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "add_r18");
`ifdef HAZARD_STATS_EN
    lu_snap   = lu_cnt;
    wait_snap = wait_cnt;
`endif
    step(1'b1, 1'b1, 5'd18, 5'd18, 1'b1, 1'b1, 5'd19, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "add_r19");
    nop(1'b1, 8'b0101_1101, "wait_with_fwd");

    // asynchronous reset in the middle of a wait
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "async_rst_in_wait");
    nop(1'b0, 8'h00, "rst_release_2");
    nop(1'b0, 8'h00, "first_sels_after_rst");
    stim_done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    int idle;
    idle = 0;
    while (!(stim_done && (exp_q.size() == 0)) && (idle < 200)) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        idle     = 0;
        checks++;
        if (act_v !== mon_exp) begin
          errors++;
          $display("FAIL %s: got a=%b b=%b pc_hold=%b ifid_hold=%b bubble=%b freeze=%b, expected {a,b,pc,ifid,bub,frz}=%b",
                   mon_name, act_v[7:6], act_v[5:4], act_v[3], act_v[2], act_v[1], act_v[0], mon_exp);
        end
      end else begin
        idle++;
      end
    end
    checks++;
    if (!stim_done || (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL drain: stim_done=%b pending=%0d, expected stim_done=1 pending=0",
               stim_done, exp_q.size());
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (lu_snap !== 32'd2) begin
      errors++;
      $display("FAIL lu_cnt: got %0d expected 2", lu_snap);
    end
    checks++;
    if (wait_snap !== 32'd4) begin
      errors++;
      $display("FAIL wait_cnt: got %0d expected 4", wait_snap);
    end
    checks++;
    if ((lu_cnt !== 32'd0) || (wait_cnt !== 32'd0)) begin
      errors++;
      $display("FAIL stats_after_rst: got lu=%0d wait=%0d expected 0 0", lu_cnt, wait_cnt);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
